// File: rtl/seg7_decimal_scanner.sv
// Multiplexed 7-segment driver for signed two's-complement values.
// A sequential double-dabble converter fills a BCD display register; a free-running
// scan counter walks the active-low digit enables and loads the matching glyph.
module seg7_decimal_scanner #(
  parameter int W          = 16,
  parameter int DIGITS     = 8,
  parameter int DIV_M      = 2**17,
  parameter int LEAD_BLANK = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              value_valid,
  input  logic [W-1:0]      value,
  output logic              busy,
  output logic              ovf,
  output logic [DIGITS-1:0] an,
  output logic [6:0]        pin
);

  localparam int NB = DIGITS - 1;          // numeric digits, top digit is the sign slot
  localparam int BW = 4 * NB;              // BCD scratch width
  localparam int CW = (DIV_M > 1) ? $clog2(DIV_M) : 1;
  localparam int SW = (W > 1) ? $clog2(W) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [6:0] GLYPH_BLANK = 7'b111_1111;
  localparam logic [6:0] GLYPH_MINUS = 7'b111_1110;
  localparam logic [6:0] GLYPH_E     = 7'b011_0000;

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  state_t          state_q, state_d;
  logic            sign_q, sign_d;
  logic [W-1:0]    mag_q, mag_d;
  logic [BW-1:0]   bcd_q, bcd_d;
  logic            carry_q, carry_d;
  logic [SW-1:0]   shift_cnt_q, shift_cnt_d;
  logic            commit;

  logic [BW-1:0]   disp_bcd_q;
  logic            disp_sign_q;
  logic            disp_ovf_q;

  logic [CW-1:0]   scan_cnt_q;
  logic [IW-1:0]   idx_q, idx_next;
  logic [DIGITS-1:0] an_q;
  logic [6:0]      pin_q;
  logic            tick;

  logic [W-1:0]    value_abs;
  logic [BW-1:0]   bcd_adj;
  logic [BW-1:0]   bcd_shift;
  logic            bit_out;
  logic [3:0]      nib [DIGITS];
  logic [IW-1:0]   msd;
  logic [6:0]      glyph;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b000_0001;
      4'd1:    seg7 = 7'b100_1111;
      4'd2:    seg7 = 7'b001_0010;
      4'd3:    seg7 = 7'b000_0110;
      4'd4:    seg7 = 7'b100_1100;
      4'd5:    seg7 = 7'b010_0100;
      4'd6:    seg7 = 7'b010_0000;
      4'd7:    seg7 = 7'b000_1111;
      4'd8:    seg7 = 7'b000_0000;
      4'd9:    seg7 = 7'b000_0100;
      default: seg7 = GLYPH_BLANK;
    endcase
  endfunction

  // Most negative input maps to 2**(W-1), which still fits as W-bit unsigned.
  assign value_abs = value[W-1] ? (~value + W'(1)) : value;

  // Double-dabble add-3 correction on every BCD nibble, then the shift.
  for (genvar gi = 0; gi < NB; gi++) begin : g_adj
    assign bcd_adj[4*gi +: 4] = (bcd_q[4*gi +: 4] >= 4'd5) ? bcd_q[4*gi +: 4] + 4'd3
                                                           : bcd_q[4*gi +: 4];
  end
  assign bcd_shift = {bcd_adj[BW-2:0], mag_q[W-1]};
  assign bit_out   = bcd_adj[BW-1];

  // Conversion state register; reset aborts any conversion in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      sign_q      <= 1'b0;
      mag_q       <= '0;
      bcd_q       <= '0;
      carry_q     <= 1'b0;
      shift_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      sign_q      <= sign_d;
      mag_q       <= mag_d;
      bcd_q       <= bcd_d;
      carry_q     <= carry_d;
      shift_cnt_q <= shift_cnt_d;
    end
  end

  // Conversion next-state: accept in IDLE, W shift steps, commit on the last one.
  always_comb begin
    state_d     = state_q;
    sign_d      = sign_q;
    mag_d       = mag_q;
    bcd_d       = bcd_q;
    carry_d     = carry_q;
    shift_cnt_d = shift_cnt_q;
    commit      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (value_valid) begin
          sign_d      = value[W-1];
          mag_d       = value_abs;
          bcd_d       = '0;
          carry_d     = 1'b0;
          shift_cnt_d = '0;
          state_d     = S_SHIFT;
        end
      end
      S_SHIFT: begin
        bcd_d       = bcd_shift;
        mag_d       = {mag_q[W-2:0], 1'b0};
        carry_d     = carry_q | bit_out;
        shift_cnt_d = shift_cnt_q + SW'(1);
        if (shift_cnt_q == SW'(W - 1)) begin
          commit  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Display registers: only a completed conversion or reset changes them.
  always_ff @(posedge clk) begin
    if (rst) begin
      disp_bcd_q  <= '0;
      disp_sign_q <= 1'b0;
      disp_ovf_q  <= 1'b0;
    end else if (commit) begin
      disp_bcd_q  <= bcd_d;
      disp_sign_q <= sign_q;
      disp_ovf_q  <= carry_d;
    end
  end

  // Per-digit nibble view; the sign slot reads as zero.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nib
    if (gi < NB) begin : g_num
      assign nib[gi] = disp_bcd_q[4*gi +: 4];
    end else begin : g_sign
      assign nib[gi] = 4'd0;
    end
  end

  // Highest nonzero digit index, 0 when the whole value is zero.
  always_comb begin
    msd = '0;
    for (int i = 0; i < NB; i++) begin
      if (nib[i] != 4'd0) msd = IW'(i);
    end
  end

  assign tick     = (scan_cnt_q == CW'(DIV_M - 1));
  assign idx_next = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);

  // Glyph for the digit that becomes active on the next tick.
  always_comb begin
    glyph = GLYPH_BLANK;
    if (disp_ovf_q) begin
      if (idx_next == '0) glyph = GLYPH_E;
    end else if (LEAD_BLANK != 0) begin
      if (idx_next <= msd) glyph = seg7(nib[idx_next]);
      else if ((idx_next == msd + IW'(1)) && disp_sign_q) glyph = GLYPH_MINUS;
    end else begin
      if (int'(idx_next) < NB) glyph = seg7(nib[idx_next]);
      else if (disp_sign_q) glyph = GLYPH_MINUS;
    end
  end

  // Scan: enable and glyph move together on each tick so they never skew.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt_q <= '0;
      idx_q      <= '0;
      an_q       <= {{(DIGITS-1){1'b1}}, 1'b0};
      pin_q      <= GLYPH_BLANK;
    end else if (tick) begin
      scan_cnt_q <= '0;
      idx_q      <= idx_next;
      an_q       <= {an_q[DIGITS-2:0], an_q[DIGITS-1]};
      pin_q      <= glyph;
    end else begin
      scan_cnt_q <= scan_cnt_q + CW'(1);
    end
  end

  assign busy = (state_q == S_SHIFT);
  assign ovf  = disp_ovf_q;
  assign an   = an_q;
  assign pin  = pin_q;

endmodule
